// File: rtl/cpu_trace_monitor.sv
// Debug/performance monitor for the multicycle core: cycle, retire and per-state
// occupancy counters, with halt on cycle limit, PC breakpoint or store watchpoint.
module cpu_trace_monitor #(
  parameter int XLEN        = 16,
  parameter int STATE_W     = 5,
  parameter int NUM_STATES  = 11,
  parameter int FETCH_STATE = 0,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic [STATE_W-1:0] state,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    adr,
  input  logic [XLEN-1:0]    writedata,
  input  logic               memwrite,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic               bp_en,
  input  logic [XLEN-1:0]    bp_pc,
  input  logic               wp_en,
  input  logic [XLEN-1:0]    wp_adr,
  input  logic [STATE_W-1:0] rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   unknown_count,
  output logic [XLEN-1:0]    last_st_adr,
  output logic [XLEN-1:0]    last_st_data,
  output logic               halted,
  output logic [1:0]         halt_cause
);

  // mode   | meaning
  // IDLE   | waiting for run, counters hold
  // RUN    | sampling core every cycle
  // HALTED | halt condition seen, everything frozen until clear
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} mode_t;

  localparam logic [STATE_W-1:0] FETCH_ST = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] NUM_ST   = STATE_W'(NUM_STATES);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  mode_t            mode, mode_nxt;
  logic [CNT_W-1:0] cyc_q, instr_q, unk_q;
  logic [CNT_W-1:0] hist_q [NUM_STATES];
  logic             prev_fetch;
  logic [XLEN-1:0]  st_adr_q, st_data_q;
  logic [1:0]       cause_q, cause_nxt;
  logic [CNT_W-1:0] cyc_inc;
  logic             is_fetch, legal, lim_hit, bp_hit, wp_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign is_fetch = (state == FETCH_ST);
  assign legal    = (state < NUM_ST);
  assign cyc_inc  = sat_inc(cyc_q);
  // limit compares against the post-increment count, so max_cycles=N halts after N cycles
  assign lim_hit  = (max_cycles != '0) && (cyc_inc == max_cycles);
  assign bp_hit   = bp_en && is_fetch && (pc == bp_pc);
  assign wp_hit   = wp_en && memwrite && (adr == wp_adr);

  always_comb begin
    cause_nxt = 2'b00;
    if (wp_hit)       cause_nxt = 2'b11;
    else if (bp_hit)  cause_nxt = 2'b10;
    else if (lim_hit) cause_nxt = 2'b01;
  end

  always_comb begin
    mode_nxt = mode;
    case (mode)
      IDLE:    if (run) mode_nxt = RUN;
      RUN:     if (cause_nxt != 2'b00) mode_nxt = HALTED;
      HALTED:  mode_nxt = HALTED;
      default: mode_nxt = IDLE;
    endcase
    if (clear) mode_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) mode <= IDLE;
    else       mode <= mode_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cyc_q      <= '0;
      instr_q    <= '0;
      unk_q      <= '0;
      prev_fetch <= 1'b0;
      cause_q    <= 2'b00;
      for (int i = 0; i < NUM_STATES; i++) hist_q[i] <= '0;
    end else if (mode == RUN) begin
      cyc_q <= cyc_inc;
      if (legal) begin
        for (int i = 0; i < NUM_STATES; i++)
          if (state == STATE_W'(i)) hist_q[i] <= sat_inc(hist_q[i]);
      end else begin
        unk_q <= sat_inc(unk_q);
      end
      if (is_fetch && !prev_fetch) instr_q <= sat_inc(instr_q);
      prev_fetch <= is_fetch;
      if (cause_nxt != 2'b00) cause_q <= cause_nxt;
    end else begin
      prev_fetch <= 1'b0;
    end
  end

  // store capture survives clear; only reset wipes it
  always_ff @(posedge clk) begin
    if (reset) begin
      st_adr_q  <= '0;
      st_data_q <= '0;
    end else if (!clear && mode == RUN && memwrite) begin
      st_adr_q  <= adr;
      st_data_q <= writedata;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_STATES; i++)
      if (rd_sel == STATE_W'(i)) rd_data = hist_q[i];
  end

  assign cycle_count   = cyc_q;
  assign instr_count   = instr_q;
  assign unknown_count = unk_q;
  assign last_st_adr   = st_adr_q;
  assign last_st_data  = st_data_q;
  assign halted        = (mode == HALTED);
  assign halt_cause    = cause_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: directed scenarios plus randomized runs checked
// against a cycle-level behavioural model.
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0, run = 1'b0, clear = 1'b0;
  logic [4:0]  state = '0;
  logic [15:0] pc = '0, adr = '0, writedata = '0;
  logic        memwrite = 1'b0;
  logic [31:0] max_cycles = '0;
  logic        bp_en = 1'b0, wp_en = 1'b0;
  logic [15:0] bp_pc = '0, wp_adr = '0;
  logic [4:0]  rd_sel = '0;
  logic [31:0] rd_data, cycle_count, instr_count, unknown_count;
  logic [15:0] last_st_adr, last_st_data;
  logic        halted;
  logic [1:0]  halt_cause;

  logic        run4 = 1'b0;
  logic [3:0]  max4 = '0;
  logic [3:0]  rd_data4, cyc4, instr4, unk4;
  logic [15:0] adr4_o, data4_o;
  logic        halted4;
  logic [1:0]  cause4;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  cpu_trace_monitor dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .state(state), .pc(pc),
    .adr(adr), .writedata(writedata), .memwrite(memwrite), .max_cycles(max_cycles),
    .bp_en(bp_en), .bp_pc(bp_pc), .wp_en(wp_en), .wp_adr(wp_adr), .rd_sel(rd_sel),
    .rd_data(rd_data), .cycle_count(cycle_count), .instr_count(instr_count),
    .unknown_count(unknown_count), .last_st_adr(last_st_adr),
    .last_st_data(last_st_data), .halted(halted), .halt_cause(halt_cause));

  cpu_trace_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run4), .clear(clear), .state(state), .pc(pc),
    .adr(adr), .writedata(writedata), .memwrite(memwrite), .max_cycles(max4),
    .bp_en(bp_en), .bp_pc(bp_pc), .wp_en(wp_en), .wp_adr(wp_adr), .rd_sel(rd_sel),
    .rd_data(rd_data4), .cycle_count(cyc4), .instr_count(instr4),
    .unknown_count(unk4), .last_st_adr(adr4_o), .last_st_data(data4_o),
    .halted(halted4), .halt_cause(cause4));

  // Behavioural model of the 32-bit instance: 0 idle, 1 run, 2 halted
  localparam longint MAXC = 64'hFFFF_FFFF;
  int     m_mode, m_cause, m_adr, m_data;
  longint m_cyc, m_instr, m_unk;
  longint m_hist[32];
  bit     m_prev;

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic void m_zero();
    m_cyc = 0; m_instr = 0; m_unk = 0; m_prev = 0; m_cause = 0;
    foreach (m_hist[i]) m_hist[i] = 0;
  endfunction

  function automatic void m_step();
    longint nc;
    int c;
    if (reset) begin
      m_zero(); m_mode = 0; m_adr = 0; m_data = 0;
    end else if (clear) begin
      m_zero(); m_mode = 0;
    end else if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_prev = 0; end
    end else if (m_mode == 1) begin
      nc = sat(m_cyc + 1);
      c = 0;
      if (wp_en && memwrite && adr == wp_adr) c = 3;
      else if (bp_en && state == 0 && pc == bp_pc) c = 2;
      else if (max_cycles != 0 && nc == longint'(max_cycles)) c = 1;
      m_cyc = nc;
      if (state < 11) m_hist[state] = sat(m_hist[state] + 1);
      else m_unk = sat(m_unk + 1);
      if (state == 0 && !m_prev) m_instr = sat(m_instr + 1);
      m_prev = (state == 0);
      if (memwrite) begin m_adr = adr; m_data = writedata; end
      if (c != 0) begin m_cause = c; m_mode = 2; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic start_run();
    clear = 1'b1; tick(); clear = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    rd_sel = 5'd0;
    #1;
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", cycle_count); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_instr got=%0d exp=0", instr_count); end
    checks++; if (unknown_count !== 32'd0) begin failures++; $display("FAIL reset_unk got=%0d exp=0", unknown_count); end
    checks++; if ({last_st_adr, last_st_data} !== 32'd0) begin failures++; $display("FAIL reset_last_st got=%0h/%0h exp=0/0", last_st_adr, last_st_data); end
    checks++; if ({halted, halt_cause} !== 3'd0) begin failures++; $display("FAIL reset_halt got=%0b/%0b exp=0/00", halted, halt_cause); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_hist got=%0d exp=0", rd_data); end
  endtask

  task automatic test_basic();
    int seq[8] = '{0, 1, 6, 7, 0, 1, 6, 7};
    run = 1'b1; tick(); run = 1'b0;
    foreach (seq[i]) begin state = 5'(seq[i]); tick(); end
    checks++; if (cycle_count !== 32'd8) begin failures++; $display("FAIL basic_cycle got=%0d exp=8", cycle_count); end
    checks++; if (instr_count !== 32'd2) begin failures++; $display("FAIL basic_instr got=%0d exp=2", instr_count); end
    rd_sel = 5'd0; #1;
    checks++; if (rd_data !== 32'd2) begin failures++; $display("FAIL basic_hist0 got=%0d exp=2", rd_data); end
    rd_sel = 5'd6; #1;
    checks++; if (rd_data !== 32'd2) begin failures++; $display("FAIL basic_hist6 got=%0d exp=2", rd_data); end
    rd_sel = 5'd20; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL basic_hist_oob got=%0d exp=0", rd_data); end
    clear = 1'b1; tick(); clear = 1'b0;
    rd_sel = 5'd0; #1;
    checks++; if ({cycle_count, instr_count, unknown_count, rd_data} !== 128'd0) begin failures++; $display("FAIL clear_counters got=%0d/%0d/%0d/%0d exp=0/0/0/0", cycle_count, instr_count, unknown_count, rd_data); end
    state = 5'd1; tick(); tick();
    checks++; if (cycle_count !== 32'd0 || halted !== 1'b0) begin failures++; $display("FAIL clear_idle got=%0d/%0b exp=0/0", cycle_count, halted); end
  endtask

  task automatic test_limit();
    max_cycles = 32'd5; state = 5'd1;
    start_run();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL limit_early got=%0b exp=0", halted); end
    tick();
    checks++; if (halted !== 1'b1 || halt_cause !== 2'b01) begin failures++; $display("FAIL limit_halt got=%0b/%0b exp=1/01", halted, halt_cause); end
    checks++; if (cycle_count !== 32'd5) begin failures++; $display("FAIL limit_cycle got=%0d exp=5", cycle_count); end
    run = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    run = 1'b0;
    checks++; if (cycle_count !== 32'd5 || halted !== 1'b1) begin failures++; $display("FAIL limit_frozen got=%0d/%0b exp=5/1", cycle_count, halted); end
    max_cycles = 32'd0;
  endtask

  task automatic test_breakpoint();
    bp_en = 1'b1; bp_pc = 16'h0004;
    start_run();
    state = 5'd0; pc = 16'h0000; tick();
    state = 5'd1; tick();
    state = 5'd0; pc = 16'h0002; tick();
    state = 5'd1; tick();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL bp_early got=%0b exp=0", halted); end
    state = 5'd0; pc = 16'h0004; tick();
    checks++; if (halted !== 1'b1 || halt_cause !== 2'b10) begin failures++; $display("FAIL bp_halt got=%0b/%0b exp=1/10", halted, halt_cause); end
    checks++; if (instr_count !== 32'd3) begin failures++; $display("FAIL bp_instr got=%0d exp=3", instr_count); end
    bp_en = 1'b0; pc = '0;
  endtask

  task automatic test_watchpoint();
    wp_en = 1'b1; wp_adr = 16'h0020;
    start_run();
    state = 5'd2; memwrite = 1'b1; adr = 16'h0010; writedata = 16'hAAAA; tick();
    checks++; if (last_st_adr !== 16'h0010 || last_st_data !== 16'hAAAA) begin failures++; $display("FAIL wp_first_store got=%0h/%0h exp=10/aaaa", last_st_adr, last_st_data); end
    state = 5'd3; memwrite = 1'b0; tick();
    state = 5'd2; memwrite = 1'b1; adr = 16'h0020; writedata = 16'h1234; tick();
    checks++; if (halted !== 1'b1 || halt_cause !== 2'b11) begin failures++; $display("FAIL wp_halt got=%0b/%0b exp=1/11", halted, halt_cause); end
    adr = 16'h0030; writedata = 16'h5555; tick();
    checks++; if (last_st_adr !== 16'h0020 || last_st_data !== 16'h1234) begin failures++; $display("FAIL wp_last_st got=%0h/%0h exp=20/1234", last_st_adr, last_st_data); end
    memwrite = 1'b0; wp_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    max_cycles = 32'd3; bp_en = 1'b1; bp_pc = 16'h0008; wp_en = 1'b1; wp_adr = 16'h0040;
    start_run();
    state = 5'd1; tick(); tick();
    state = 5'd0; pc = 16'h0008; memwrite = 1'b1; adr = 16'h0040; tick();
    checks++; if (halted !== 1'b1 || halt_cause !== 2'b11) begin failures++; $display("FAIL simul_cause got=%0b/%0b exp=1/11", halted, halt_cause); end
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("FAIL simul_cycle got=%0d exp=3", cycle_count); end
    max_cycles = '0; bp_en = 1'b0; wp_en = 1'b0; memwrite = 1'b0; pc = '0;
  endtask

  task automatic test_unknown();
    start_run();
    state = 5'd2; tick();
    state = 5'd31; tick(); tick(); tick();
    checks++; if (unknown_count !== 32'd3) begin failures++; $display("FAIL unk_count got=%0d exp=3", unknown_count); end
    for (int s = 0; s < 11; s++) begin
      rd_sel = 5'(s); #1;
      checks++; if (rd_data !== ((s == 2) ? 32'd1 : 32'd0)) begin failures++; $display("FAIL unk_hist%0d got=%0d exp=%0d", s, rd_data, (s == 2) ? 1 : 0); end
    end
  endtask

  task automatic test_saturation();
    clear = 1'b1; tick(); clear = 1'b0;
    state = 5'd0;
    run4 = 1'b1; tick(); run4 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (cyc4 !== 4'd15) begin failures++; $display("FAIL sat_cycle got=%0d exp=15", cyc4); end
    checks++; if (halted4 !== 1'b0) begin failures++; $display("FAIL sat_nohalt got=%0b exp=0", halted4); end
    rd_sel = 5'd0; #1;
    checks++; if (rd_data4 !== 4'd15 || instr4 !== 4'd1) begin failures++; $display("FAIL sat_hist got=%0d/%0d exp=15/1", rd_data4, instr4); end
  endtask

  task automatic test_random();
    int pcs[4] = '{0, 2, 4, 6};
    int adrs[3] = '{16'h10, 16'h20, 16'h30};
    for (int it = 0; it < 6; it++) begin
      max_cycles = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(10, 60)) : 32'd0;
      bp_en = (it % 3 == 1); bp_pc = 16'(pcs[$urandom_range(0, 3)]);
      wp_en = (it % 3 == 2); wp_adr = 16'(adrs[$urandom_range(0, 2)]);
      start_run();
      for (int n = 0; n < 70; n++) begin
        state = ($urandom_range(0, 7) == 0) ? 5'(31 - $urandom_range(0, 15)) : 5'($urandom_range(0, 10));
        pc = 16'(pcs[$urandom_range(0, 3)]);
        memwrite = ($urandom_range(0, 3) == 0);
        adr = 16'(adrs[$urandom_range(0, 2)]);
        writedata = 16'($urandom);
        rd_sel = 5'($urandom_range(0, 31));
        if (n == 35) bp_pc = 16'(pcs[$urandom_range(0, 3)]);
        tick();
        checks++;
        if (longint'(cycle_count) !== m_cyc || longint'(instr_count) !== m_instr ||
            longint'(unknown_count) !== m_unk || longint'(rd_data) !== m_hist[rd_sel]) begin
          failures++;
          $display("FAIL rand_counts it=%0d n=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", it, n,
                   cycle_count, instr_count, unknown_count, rd_data, m_cyc, m_instr, m_unk, m_hist[rd_sel]);
        end
        checks++;
        if (halted !== (m_mode == 2) || int'(halt_cause) !== m_cause ||
            int'(last_st_adr) !== m_adr || int'(last_st_data) !== m_data) begin
          failures++;
          $display("FAIL rand_status it=%0d n=%0d got=%0b/%0d/%0h/%0h exp=%0b/%0d/%0h/%0h", it, n,
                   halted, halt_cause, last_st_adr, last_st_data, m_mode == 2, m_cause, m_adr, m_data);
        end
      end
    end
    max_cycles = '0; bp_en = 1'b0; wp_en = 1'b0; memwrite = 1'b0;
  endtask

  task automatic test_reset_midrun();
    start_run();
    state = 5'd0; memwrite = 1'b1; adr = 16'h0010; writedata = 16'hBEEF; tick();
    state = 5'd3; tick();
    checks++; if (cycle_count !== 32'd2) begin failures++; $display("FAIL midrun_pre got=%0d exp=2", cycle_count); end
    reset = 1'b1; tick(); reset = 1'b0; memwrite = 1'b0;
    rd_sel = 5'd0; #1;
    checks++;
    if ({cycle_count, instr_count, unknown_count, rd_data} !== 128'd0 ||
        {last_st_adr, last_st_data} !== 32'd0 || {halted, halt_cause} !== 3'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%0d/%0d/%0d/%0d/%0h/%0h/%0b/%0b exp=all0", cycle_count, instr_count,
               unknown_count, rd_data, last_st_adr, last_st_data, halted, halt_cause);
    end
    tick();
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL midrun_idle got=%0d exp=0", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit();
    test_breakpoint();
    test_watchpoint();
    test_simultaneous();
    test_unknown();
    test_saturation();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_monitor.md
Name: cpu_trace_monitor

Overview:
- Synthesizable, parametrised debug/performance monitor that taps the multicycle core's FSM state, PC and memory-write bus.
- Counts cycles, retired instructions and per-state occupancy.
- Halts the trace on a cycle limit, PC breakpoint or store watchpoint.
- Sits beside NITCRisc24 in simulation and FPGA builds; replaces fixed-length, print-based cycle tracing.

Parameters:
- XLEN, 16: width of pc, adr and writedata.
- STATE_W, 5: width of the core state bus.
- NUM_STATES, 11: number of legal state encodings, 0..NUM_STATES-1; higher encodings are "unknown".
- FETCH_STATE, 0: encoding of the FETCH state.
- CNT_W, 32: width of every counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start request; sampled in IDLE.
- clear  in  1  return to IDLE and zero all counters.
- state  in  STATE_W  core FSM state.
- pc  in  XLEN  core PC.
- adr  in  XLEN  core memory address.
- writedata  in  XLEN  core store data.
- memwrite  in  1  core store strobe.
- max_cycles  in  CNT_W  cycle limit; 0 = unlimited.
- bp_en  in  1  PC breakpoint enable.
- bp_pc  in  XLEN  breakpoint PC.
- wp_en  in  1  store watchpoint enable.
- wp_adr  in  XLEN  watched store address.
- rd_sel  in  STATE_W  state histogram read select.
- rd_data  out  CNT_W  histogram count for rd_sel, combinational; 0 if rd_sel >= NUM_STATES.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instr_count  out  CNT_W  FETCH entries.
- unknown_count  out  CNT_W  cycles with an illegal state.
- last_st_adr  out  XLEN  address of the most recent store seen in RUN.
- last_st_data  out  XLEN  data of the most recent store seen in RUN.
- halted  out  1  monitor is in HALTED.
- halt_cause  out  2  00 none, 01 limit, 10 breakpoint, 11 watchpoint.

Behaviour:
- Reset:
  - mode = IDLE.
  - All counters, histogram entries, last_st_*, halted and halt_cause = 0.
  - prev_fetch = 0.
- Mode FSM, 2-bit IDLE/RUN/HALTED:
  - IDLE -> RUN when run=1.
  - RUN -> HALTED on any halt condition.
  - Any mode -> IDLE on clear=1; counters zeroed in the same edge.
  - clear has priority over run and over halt detection.
  - reset has priority over everything.
- Per RUN cycle, sampled at the rising edge:
  - cycle_count += 1.
  - If state < NUM_STATES: hist[state] += 1; else unknown_count += 1.
  - instr_count += 1 when state==FETCH_STATE and prev_fetch==0.
  - prev_fetch <= (state==FETCH_STATE). prev_fetch is cleared on entry to RUN, so a run starting in FETCH counts that fetch.
  - If memwrite=1: last_st_adr <= adr and last_st_data <= writedata.
- Saturation: every counter saturates at 2^CNT_W-1. It never wraps.
- Halt conditions, evaluated on the same sample as the counter updates:
  - Limit: max_cycles != 0 and the incremented cycle_count == max_cycles.
  - Breakpoint: bp_en and state==FETCH_STATE and pc==bp_pc.
  - Watchpoint: wp_en and memwrite and adr==wp_adr.
- Simultaneous halt conditions: cause priority is watchpoint > breakpoint > limit.
- Halt timing: halted and halt_cause are registered, valid the edge after the triggering sample. The triggering cycle is itself counted, and its store is captured.
- HALTED: all counters and last_st_* frozen; core inputs ignored; halted=1 until clear or reset.
- run in RUN or HALTED: no effect.
- Changing max_cycles/bp/wp mid-RUN takes effect on the next sample.

Test Plan:
- Reset, then run=1 with state sequence 0,1,6,7,0,1,6,7 (8 RUN cycles), then clear. Before clear: cycle_count=8, instr_count=2, rd_sel=0 -> rd_data=2, rd_sel=6 -> rd_data=2. After clear: all counters 0, mode IDLE.
- max_cycles=5, state held at 1 -> halted=1 with halt_cause=01 after the 5th RUN cycle; cycle_count=5 and stays 5 over 10 more cycles.
- bp_en=1, bp_pc=0x0004; pc steps 0,2,4 on FETCH visits -> halt_cause=10; instr_count=3.
- wp_en=1, wp_adr=0x0020; stores to 0x0010 (data 0xAAAA), then 0x0020 (data 0x1234) -> halt_cause=11, last_st_adr=0x0020, last_st_data=0x1234.
- Watchpoint and breakpoint on the same cycle with max_cycles reached -> halt_cause=11.
- state=5'b11111 for 3 cycles -> unknown_count=3, histogram unchanged.
- CNT_W=4 build, 20 RUN cycles with max_cycles=0 -> cycle_count=15, no halt.
- reset asserted mid-RUN -> all outputs 0 next edge.
